// File: rtl/simon3264_round_pipeline_if.sv
// Block/key/tag handshake between the cipher-core controller, the SIMON 32/64
// pipeline and the ciphertext writer.
interface simon3264_round_pipeline_if #(
  parameter int TAG_W = 11
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_plaintext;
  logic [63:0]      in_key;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_ciphertext;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output in_valid, in_plaintext, in_key, in_tag, out_ready,
    input  in_ready, out_valid, out_ciphertext, out_tag, busy
  );

  modport slave (
    input  in_valid, in_plaintext, in_key, in_tag, out_ready,
    output in_ready, out_valid, out_ciphertext, out_tag, busy
  );
endinterface

// File: rtl/simon3264_round_pipeline.sv
// Unrolled SIMON 32/64 encryption pipeline: ROUNDS_PER_STAGE rounds per register
// stage, key schedule carried alongside each block, single global stall.
module simon3264_round_pipeline #(
  parameter int ROUNDS_PER_STAGE = 4,
  parameter int TAG_W            = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  simon3264_round_pipeline_if.slave bus
);
  localparam int STAGES = 32 / ROUNDS_PER_STAGE;
  // z0 sequence; character i from the left sits at bit 61-i
  localparam logic [61:0] Z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;

  if (!(ROUNDS_PER_STAGE == 1 || ROUNDS_PER_STAGE == 2 || ROUNDS_PER_STAGE == 4 ||
        ROUNDS_PER_STAGE == 8 || ROUNDS_PER_STAGE == 16 || ROUNDS_PER_STAGE == 32))
  begin : g_bad_rounds
    $error("ROUNDS_PER_STAGE must be 1, 2, 4, 8, 16 or 32");
  end

  function automatic logic [15:0] rol16(input logic [15:0] v, input int unsigned n);
    return (v << n) | (v >> (16 - n));
  endfunction

  logic             st_valid [STAGES];
  logic [31:0]      st_state [STAGES];
  logic [63:0]      st_key   [STAGES];
  logic [5:0]       st_rnd   [STAGES];
  logic [TAG_W-1:0] st_tag   [STAGES];
  logic [STAGES-1:0] valid_vec;
  logic             adv;

  assign adv = ~st_valid[STAGES-1] | bus.out_ready;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic             src_valid;
    logic [31:0]      src_state;
    logic [63:0]      src_key;
    logic [5:0]       src_rnd;
    logic [TAG_W-1:0] src_tag;
    logic [15:0]      cx, cy, cnx, ct, knew;
    logic [63:0]      ck;
    logic [5:0]       crnd;

    if (s == 0) begin : g_src_in
      assign src_valid = bus.in_valid;
      assign src_state = bus.in_plaintext;
      assign src_key   = bus.in_key;
      assign src_rnd   = 6'd0;
      assign src_tag   = bus.in_tag;
    end else begin : g_src_prev
      assign src_valid = st_valid[s-1];
      assign src_state = st_state[s-1];
      assign src_key   = st_key[s-1];
      assign src_rnd   = st_rnd[s-1];
      assign src_tag   = st_tag[s-1];
    end

    // ck holds {k[i+3], k[i+2], k[i+1], k[i]} for the round currently applied
    always_comb begin
      cx   = src_state[31:16];
      cy   = src_state[15:0];
      ck   = src_key;
      crnd = src_rnd;
      ct   = '0;
      knew = '0;
      cnx  = '0;
      for (int j = 0; j < ROUNDS_PER_STAGE; j++) begin
        ct   = rol16(ck[63:48], 13) ^ ck[31:16];
        ct   = ct ^ rol16(ct, 15);
        knew = ~ck[15:0] ^ ct ^ {15'd0, Z0[6'd61 - crnd]} ^ 16'h0003;
        cnx  = cy ^ ((rol16(cx, 1) & rol16(cx, 8)) ^ rol16(cx, 2)) ^ ck[15:0];
        cy   = cx;
        cx   = cnx;
        ck   = {knew, ck[63:16]};
        crnd = crnd + 6'd1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        st_valid[s] <= 1'b0;
        st_state[s] <= '0;
        st_key[s]   <= '0;
        st_rnd[s]   <= '0;
        st_tag[s]   <= '0;
      end else if (adv) begin
        st_valid[s] <= src_valid;
        st_state[s] <= {cx, cy};
        st_key[s]   <= ck;
        st_rnd[s]   <= crnd;
        st_tag[s]   <= src_tag;
      end
    end

    assign valid_vec[s] = st_valid[s];
  end

  assign bus.in_ready       = adv;
  assign bus.out_valid      = st_valid[STAGES-1];
  assign bus.out_ciphertext = st_state[STAGES-1];
  assign bus.out_tag        = st_tag[STAGES-1];
  assign bus.busy           = |valid_vec;
endmodule

// File: tb/tb_simon3264_round_pipeline.sv
// Randomized bench for simon3264_round_pipeline against a software SIMON 32/64 model.
module tb_simon3264_round_pipeline;
  localparam int STAGES = 8;
  localparam logic [63:0] STD_KEY = 64'h1918_1110_0908_0100;
  localparam logic [31:0] STD_PT  = 32'h6565_6877;
  localparam logic [31:0] STD_CT  = 32'hC69B_E9BB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  simon3264_round_pipeline_if #(.TAG_W(11)) bus ();
  simon3264_round_pipeline #(.ROUNDS_PER_STAGE(4), .TAG_W(11)) dut (.clk(clk), .rst(rst), .bus(bus));

  // parameter sweep instances share one stimulus
  logic        sw_valid = 1'b0;
  logic [31:0] sw_pt    = '0;
  logic [63:0] sw_key   = '0;
  simon3264_round_pipeline_if #(.TAG_W(11)) sw1 ();
  simon3264_round_pipeline_if #(.TAG_W(11)) sw2 ();
  simon3264_round_pipeline_if #(.TAG_W(11)) sw16 ();
  simon3264_round_pipeline_if #(.TAG_W(11)) sw32 ();
  simon3264_round_pipeline #(.ROUNDS_PER_STAGE(1),  .TAG_W(11)) dut_r1  (.clk(clk), .rst(rst), .bus(sw1));
  simon3264_round_pipeline #(.ROUNDS_PER_STAGE(2),  .TAG_W(11)) dut_r2  (.clk(clk), .rst(rst), .bus(sw2));
  simon3264_round_pipeline #(.ROUNDS_PER_STAGE(16), .TAG_W(11)) dut_r16 (.clk(clk), .rst(rst), .bus(sw16));
  simon3264_round_pipeline #(.ROUNDS_PER_STAGE(32), .TAG_W(11)) dut_r32 (.clk(clk), .rst(rst), .bus(sw32));
  assign sw1.in_valid  = sw_valid; assign sw1.in_plaintext  = sw_pt; assign sw1.in_key  = sw_key;
  assign sw1.in_tag    = 11'd1;    assign sw1.out_ready     = 1'b1;
  assign sw2.in_valid  = sw_valid; assign sw2.in_plaintext  = sw_pt; assign sw2.in_key  = sw_key;
  assign sw2.in_tag    = 11'd2;    assign sw2.out_ready     = 1'b1;
  assign sw16.in_valid = sw_valid; assign sw16.in_plaintext = sw_pt; assign sw16.in_key = sw_key;
  assign sw16.in_tag   = 11'd16;   assign sw16.out_ready    = 1'b1;
  assign sw32.in_valid = sw_valid; assign sw32.in_plaintext = sw_pt; assign sw32.in_key = sw_key;
  assign sw32.in_tag   = 11'd32;   assign sw32.out_ready    = 1'b1;

  logic [3:0]  sw_ov;
  logic [31:0] sw_ct [4];
  assign sw_ov = {sw32.out_valid, sw16.out_valid, sw2.out_valid, sw1.out_valid};
  assign sw_ct[0] = sw1.out_ciphertext;
  assign sw_ct[1] = sw2.out_ciphertext;
  assign sw_ct[2] = sw16.out_ciphertext;
  assign sw_ct[3] = sw32.out_ciphertext;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rol(input logic [15:0] v, input int n);
    return (v << n) | (v >> (16 - n));
  endfunction

  function automatic logic [15:0] ror(input logic [15:0] v, input int n);
    return (v >> n) | (v << (16 - n));
  endfunction

  // Straight software SIMON 32/64: expand all round keys, then run 32 rounds
  function automatic logic [31:0] simon_ref(input logic [31:0] pt, input logic [63:0] key);
    string       zs = "11111010001001010110000111001101111101000100101011000011100110";
    logic [15:0] k [32];
    logic [15:0] x, y, t;
    k[0] = key[15:0];
    k[1] = key[31:16];
    k[2] = key[47:32];
    k[3] = key[63:48];
    for (int i = 0; i < 28; i++) begin
      t = ror(k[i+3], 3) ^ k[i+1];
      t = t ^ ror(t, 1);
      k[i+4] = ~k[i] ^ t ^ ((zs[i] == "1") ? 16'h0001 : 16'h0000) ^ 16'h0003;
    end
    x = pt[31:16];
    y = pt[15:0];
    for (int i = 0; i < 32; i++) begin
      t = x;
      x = y ^ ((rol(x, 1) & rol(x, 8)) ^ rol(x, 2)) ^ k[i];
      y = t;
    end
    return {x, y};
  endfunction

  // scoreboard: {tag, ciphertext} expected in acceptance order
  logic [42:0] exp_q [$];
  int          acc_cyc [$];
  int          hs_cyc [$];
  int          cyc = 0;
  logic        stall_prev = 1'b0;
  logic [42:0] held = '0;
  logic [42:0] mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_prev <= 1'b0;
    end else begin
      chk("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
      if (stall_prev)
        chk("stall_hold", {bus.out_valid, bus.out_tag, bus.out_ciphertext}, {1'b1, held});
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_data", {bus.out_tag, bus.out_ciphertext}, mon_e);
        end
        hs_cyc.push_back(cyc);
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back({bus.in_tag, simon_ref(bus.in_plaintext, bus.in_key)});
        acc_cyc.push_back(cyc);
      end
      stall_prev <= bus.out_valid && !bus.out_ready;
      held       <= {bus.out_tag, bus.out_ciphertext};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_std(input string nm, input logic [10:0] tg);
    int lat;
    bus.in_valid     = 1'b1;
    bus.in_plaintext = STD_PT;
    bus.in_key       = STD_KEY;
    bus.in_tag       = tg;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({nm, "_latency"}, lat, STAGES);
    chk({nm, "_ct"}, bus.out_ciphertext, STD_CT);
    chk({nm, "_tag"}, bus.out_tag, tg);
    tick();
  endtask

  task automatic drain(input string nm, input bit rnd_ready);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    bus.out_ready = 1'b1;
    chk({nm, "_drain"}, exp_q.size(), 0);
    chk({nm, "_busy"}, bus.busy, 0);
  endtask

  task automatic rand_block(input logic [10:0] tg);
    bus.in_plaintext = $urandom;
    bus.in_key       = {$urandom, $urandom};
    bus.in_tag       = tg;
  endtask

  initial begin
    int cnt;
    int g;
    bit accepted;
    int   sw_lat [4];
    logic [31:0] sw_got [4];
    bit   seen [4];
    int   exp_lat [4] = '{32, 16, 2, 1};

    bus.in_valid     = 1'b0;
    bus.in_plaintext = '0;
    bus.in_key       = '0;
    bus.in_tag       = '0;
    bus.out_ready    = 1'b1;

    // reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_ct", bus.out_ciphertext, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_sweep_valid", sw_ov, 0);
    rst = 1'b0;
    tick();

    run_std("std", 11'h5A5);

    // back-to-back, 16 random keys
    acc_cyc.delete();
    hs_cyc.delete();
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      rand_block(11'(i));
      tick();
    end
    bus.in_valid = 1'b0;
    drain("b2b", 1'b0);
    chk("b2b_count", hs_cyc.size(), 16);
    if (hs_cyc.size() == 16) chk("b2b_span", hs_cyc[15] - hs_cyc[0], 15);

    // backpressure, source holds data until accepted
    hs_cyc.delete();
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      rand_block(11'(200 + i));
      accepted = 1'b0;
      g = 0;
      while (!accepted && g < 100) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        #1;
        accepted = bus.in_ready;
        tick();
        g++;
      end
      chk("bp_accept", accepted, 1);
    end
    bus.in_valid = 1'b0;
    drain("bp", 1'b1);
    chk("bp_count", hs_cyc.size(), 10);

    // bubbles: one block every third cycle
    acc_cyc.delete();
    hs_cyc.delete();
    for (int i = 0; i < 24; i++) begin
      bus.in_valid = (i % 3 == 0);
      rand_block(11'(300 + i));
      tick();
    end
    bus.in_valid = 1'b0;
    drain("bub", 1'b0);
    chk("bub_count", hs_cyc.size(), 8);
    for (int k = 0; k < hs_cyc.size() && k < acc_cyc.size(); k++)
      chk("bub_latency", hs_cyc[k] - acc_cyc[k], STAGES);

    // reset while five blocks are in flight
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      rand_block(11'(400 + i));
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_out_ct", bus.out_ciphertext, 0);
    cnt = 0;
    repeat (12) begin
      tick();
      cnt += int'(bus.out_valid);
    end
    chk("midrst_no_out", cnt, 0);
    run_std("post_rst", 11'h0C3);

    // parameter sweep on the standard vector
    for (int d = 0; d < 4; d++) begin
      seen[d]   = 1'b0;
      sw_lat[d] = 0;
      sw_got[d] = '0;
    end
    sw_valid = 1'b1;
    sw_pt    = STD_PT;
    sw_key   = STD_KEY;
    tick();
    sw_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      for (int d = 0; d < 4; d++) begin
        if (sw_ov[d] && !seen[d]) begin
          seen[d]   = 1'b1;
          sw_lat[d] = n;
          sw_got[d] = sw_ct[d];
        end
      end
      tick();
    end
    for (int d = 0; d < 4; d++) begin
      chk("sweep_latency", sw_lat[d], exp_lat[d]);
      chk("sweep_ct", sw_got[d], STD_CT);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/simon3264_round_pipeline.md
# simon3264_round_pipeline

Parameterised, fully pipelined SIMON 32/64 encryption datapath. It sits directly downstream of the cipher-core controller: it accepts one plaintext block, a 64-bit key and a block tag per cycle, and returns the ciphertext with the same tag a fixed number of cycles later. The round function and key schedule are unrolled into `STAGES = 32 / ROUNDS_PER_STAGE` register stages. The key travels with each block, so consecutive blocks may use different keys. A single valid/ready stall lets the ciphertext BRAM writer apply backpressure.

## Interface
- `ROUNDS_PER_STAGE`, default 4: rounds computed combinationally per stage. Legal values are 1, 2, 4, 8, 16, 32; any other value is an elaboration error.
- `TAG_W`, default 11: width of the tag carried alongside each block (the block index).
- `clk`  input  1: system clock; all state updates on its rising edge.
- `rst`  input  1: synchronous reset, active-high.
- `in_valid`  input  1: `in_plaintext`, `in_key` and `in_tag` are valid.
- `in_ready`  output  1: pipeline can advance this cycle.
- `in_plaintext`  input  32: the block; x = `[31:16]`, y = `[15:0]`.
- `in_key`  input  64: key words k3 = `[63:48]`, k2 = `[47:32]`, k1 = `[31:16]`, k0 = `[15:0]`.
- `in_tag`  input  TAG_W: opaque tag, returned unchanged.
- `out_valid`  output  1: the final stage holds a finished block.
- `out_ready`  input  1: the consumer accepts the block this cycle.
- `out_ciphertext`  output  32: result; x = `[31:16]`, y = `[15:0]`.
- `out_tag`  output  TAG_W: tag of the block on `out_ciphertext`.
- `busy`  output  1: OR of all stage valid bits.

## Operation
- Each stage register holds:
  - valid bit;
  - 32-bit state {x, y};
  - 64-bit key window {k[i+3], k[i+2], k[i+1], k[i]} for its next round i;
  - round index (6 bits, 0..32);
  - tag.
- Round i, with S^j meaning left rotate by j on 16 bits:
  - f(x) = (S^1 x & S^8 x) ^ S^2 x
  - x' = y ^ f(x) ^ k[i]
  - y' = x
- Key schedule, with m = 4 and all arithmetic on 16-bit words:
  - t = S^-3 k[i+3] ^ k[i+1]
  - t = t ^ S^-1 t
  - k[i+4] = ~k[i] ^ t ^ z0[i mod 62] ^ 16'h0003
  - The window then shifts to {k[i+4], k[i+3], k[i+2], k[i+1]}.
- z0 = 11111010001001010110000111001101111101000100101011000011100110. Bit i is character i counted from the left, i = 0..61. It is held as a 62-bit constant.
- Stage s applies rounds s·R .. s·R+R−1, where R = ROUNDS_PER_STAGE. Stage 0 takes its inputs directly from the `in_*` ports with round index 0.
- Key-window update after round 31 is don't-care.
- Advance condition: adv = ~out_valid | out_ready. `in_ready` = adv.
- When adv = 1:
  - every stage loads from the stage before it;
  - stage 0 loads from the input, with valid = `in_valid`.
- When adv = 0: all stages hold, including invalid bubbles.
- Bubbles propagate as valid = 0. Their data registers may load anything, but valid = 0 entries never raise `out_valid`.
- `out_*` are driven directly from the last stage register; there is no combinational path from input to output.
- `busy` = 1 whenever any stage has valid = 1.

## Timing
- Reset, any cycle with `rst` = 1 at the edge: all valid bits are 0 after the edge, and stage data is cleared to 0.
  - `out_valid` = 0, `out_ciphertext` = 0, `out_tag` = 0, `busy` = 0, `in_ready` = 1.
- Reset mid-operation: every in-flight block is discarded with no output. The first block accepted after reset is unaffected by earlier traffic.
- Latency: a block accepted in cycle c (`in_valid` & `in_ready` at the end of c) appears with `out_valid` = 1 in cycle c + STAGES, provided adv stayed 1 throughout.
  - Default STAGES = 8. With R = 32, latency is 1.
- Throughput: one block per cycle while `out_ready` = 1.
- Stall: with `out_valid` = 1 and `out_ready` = 0:
  - `in_ready` = 0 in the same cycle;
  - `out_ciphertext` and `out_tag` stay stable until the handshake completes.
- Simultaneous output handshake and input acceptance in one cycle is legal. Both transfers complete at that edge.
- `in_valid` = 1 with `in_ready` = 0: nothing is captured, and the source must hold its data.
- Ordering is strict FIFO; blocks are never reordered or dropped except by reset.
- Round index reaches 32 in the last stage. It is not exported.

## Test plan
- Standard vector: key `64'h1918_1110_0908_0100`, plaintext `32'h6565_6877` → `out_ciphertext` = `32'hC69B_E9BB` exactly 8 cycles after acceptance, with the tag echoed.
- Back-to-back: 16 blocks with tags 0..15, each with a different random key → outputs in tag order, one per cycle, all matching a software SIMON model. `busy` drops the cycle after the last output handshake.
- Backpressure: stream 10 blocks while `out_ready` toggles pseudo-randomly → `in_ready` equals `~out_valid | out_ready` every cycle, `out_*` is stable while stalled, and there is no loss or duplication.
- Bubbles: `in_valid` asserted every third cycle → `out_valid` follows the same pattern delayed by 8 cycles, with correct data.
- Reset mid-flight: accept 5 blocks, assert `rst` for 1 cycle at cycle 3 → `out_valid` = 0 and `busy` = 0 afterwards. The next block, using the standard vector, still gives `32'hC69B_E9BB`.
- Parameter sweep: ROUNDS_PER_STAGE = 1, 2, 16, 32 on the standard vector → latency of 32, 16, 2 and 1 cycles respectively, with identical ciphertext.
